// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: services held dmemREN/dmemWEN requests against a variable-latency RAM port.
// Optional ramready watchdog enabled by defining DMEM_TIMEOUT_EN (limit set by TO_CYC).
module dmem_responder #(
  parameter int ADDR_W = 32,
  parameter int TO_CYC = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [31:0]       dmemstore,
  output logic              dhit,
  output logic [31:0]       dmemload,
  output logic              derr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic              ramready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_r;
  logic   flush_r;
  logic   req_s;
  logic   misalign_s;
  logic   to_hit_s;

  assign req_s      = dmemREN | dmemWEN;
  assign misalign_s = (dmemaddr[1:0] != 2'b00);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

  logic [CNT_W-1:0] to_cnt_r;

  // Watchdog: counts ACCESS cycles, held at zero everywhere else
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt_r <= '0;
    end else if (state_r != ACCESS) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end
  end

  // Fires on the ACCESS edge that completes the TO_CYC-th cycle
  assign to_hit_s = (to_cnt_r == CNT_W'(TO_CYC - 1));
`else
  logic unused_to_cyc_s;

  assign to_hit_s        = 1'b0;
  assign unused_to_cyc_s = (TO_CYC == 32'sd0);
`endif

  // Request/response FSM; every output is a register of this block
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      flush_r  <= 1'b0;
      dhit     <= 1'b0;
      derr     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= 32'h0000_0000;
      dmemload <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            ramaddr  <= dmemaddr;
            ramstore <= dmemstore;
            flush_r  <= 1'b0;
            if (misalign_s) begin
              dhit    <= 1'b1;
              derr    <= 1'b1;
              state_r <= RESP;
            end else begin
              // A combined REN+WEN request is serviced as a write
              ramWEN  <= dmemWEN;
              ramREN  <= dmemREN & ~dmemWEN;
              state_r <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ramready) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (flush_r || !req_s) begin
              state_r <= IDLE;
            end else begin
              if (ramREN) begin
                dmemload <= ramload;
              end
              // dhit follows one cycle later, raised from RESP
              state_r <= RESP;
            end
          end else if (to_hit_s) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (flush_r || !req_s) begin
              state_r <= IDLE;
            end else begin
              dhit    <= 1'b1;
              derr    <= 1'b1;
              state_r <= RESP;
            end
          end else if (!req_s) begin
            flush_r <= 1'b1;
          end
        end
        RESP: begin
          if (dhit) begin
            dhit    <= 1'b0;
            derr    <= 1'b0;
            state_r <= IDLE;
          end else begin
            dhit <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          dhit    <= 1'b0;
          derr    <= 1'b0;
          ramREN  <= 1'b0;
          ramWEN  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder; a transaction-level model predicts each cycle.
// Define DMEM_TIMEOUT_EN for both files to exercise the watchdog (TO_CYC=4).
module tb_dmem_responder;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO_P  = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO_P  = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK;
  logic        nRST;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        derr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  int checks;
  int errors;

  logic [31:0] ram_mem [256];
  logic [31:0] shadow  [256];
  logic [31:0] exp_load;

  dmem_responder #(.ADDR_W(32), .TO_CYC(TO_P)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .derr(derr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic noise();
    ramready = 1'($urandom_range(0, 1));
    ramload  = $urandom;
  endtask

  // One requester transaction, outputs predicted from request kind, wait count and flush point
  task automatic txn(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] data, input int waits, input int flush_at);
    bit mis, rd, wr, tmo, fl, upd;
    int strobe_n, hit_k, last_k;
    logic [31:0] old_load, new_load;
    logic [7:0] idx;
    mis = (addr[1:0] != 2'b00);
    rd  = ren && !wen;
    wr  = wen;
    tmo = TO_EN && !mis && (waits + 1 > TO_P);
    fl  = !mis && !tmo && (flush_at > 0);
    idx = addr[9:2];
    strobe_n = mis ? 0 : (tmo ? TO_P : waits + 1);
    if (mis)      hit_k = 1;
    else if (fl)  hit_k = 0;
    else if (tmo) hit_k = TO_P + 1;
    else          hit_k = waits + 3;
    last_k   = (hit_k > 0) ? hit_k + 1 : strobe_n + 2;
    old_load = exp_load;
    upd      = rd && !mis && !tmo && !fl;
    new_load = upd ? shadow[idx] : old_load;
    if (wr && !mis && !tmo) shadow[idx] = data;
    exp_load = new_load;

    dmemREN   = ren;
    dmemWEN   = wen;
    dmemaddr  = addr;
    dmemstore = data;
    noise();
    for (int k = 1; k <= last_k; k++) begin
      @(posedge CLK);
      #1;
      check("ramREN", ramREN, rd && (k <= strobe_n));
      check("ramWEN", ramWEN, wr && (k <= strobe_n));
      if (k <= strobe_n) begin
        check("ramaddr", ramaddr, addr);
        check("ramstore", ramstore, data);
      end
      check("dhit", dhit, k == hit_k);
      check("derr", derr, (k == hit_k) && (mis || tmo));
      if (k <= strobe_n || mis) check("dmemload_hold", dmemload, old_load);
      else if (hit_k > 0 && k >= hit_k) check("dmemload", dmemload, new_load);
      else if (k == last_k) check("dmemload_flush", dmemload, old_load);
      // RAM side of the environment
      if (k < strobe_n || (k == strobe_n && tmo)) begin
        ramready = 1'b0;
      end else if (k == strobe_n) begin
        if (ramWEN) ram_mem[ramaddr[9:2]] = ramstore;
        ramload  = ram_mem[ramaddr[9:2]];
        ramready = 1'b1;
      end else begin
        noise();
      end
      if (fl && k == flush_at) begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
    end
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  initial begin
    logic [31:0] a, v;
    int r, w, f;
    bit t;
    checks   = 0;
    errors   = 0;
    exp_load = 32'h0000_0000;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      shadow[i]  = v;
    end

    // Reset with random inputs
    nRST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dmemREN   = 1'($urandom_range(0, 1));
      dmemWEN   = 1'($urandom_range(0, 1));
      dmemaddr  = $urandom;
      dmemstore = $urandom;
      noise();
      @(posedge CLK);
      #1;
      check("rst_dhit", dhit, 1'b0);
      check("rst_derr", derr, 1'b0);
      check("rst_ramREN", ramREN, 1'b0);
      check("rst_ramWEN", ramWEN, 1'b0);
      check("rst_ramaddr", ramaddr, 32'h0);
      check("rst_ramstore", ramstore, 32'h0);
      check("rst_dmemload", dmemload, 32'h0);
    end
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    nRST    = 1'b1;
    @(posedge CLK);
    #1;

    // Directed cases
    ram_mem[8'h10] = 32'hDEAD_BEEF;
    shadow[8'h10]  = 32'hDEAD_BEEF;
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 0);
    check("read_beef", dmemload, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 3, 0);
    check("write_keeps_load", dmemload, 32'hDEAD_BEEF);
    check("write_committed", ram_mem[8'h40], 32'h1234_5678);
    txn(1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 2, 0);
    check("renwen_write", ram_mem[8'h02], 32'hCAFE_F00D);
    txn(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 3, 2);
    txn(1'b0, 1'b1, 32'h0000_0084, 32'h5555_AAAA, 1, 1);
    check("flush_write_committed", ram_mem[8'h21], 32'h5555_AAAA);
    txn(1'b1, 1'b0, 32'h0000_0084, 32'h0, 0, 0);
    check("read_after_flush_write", dmemload, 32'h5555_AAAA);
`ifdef DMEM_TIMEOUT_EN
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 10, 0);
    txn(1'b0, 1'b1, 32'h0000_0044, 32'h7777_0000, 6, 0);
`endif

    // Reset in the middle of an access
    dmemREN  = 1'b1;
    dmemWEN  = 1'b0;
    dmemaddr = 32'h0000_0080;
    ramready = 1'b0;
    @(posedge CLK);
    #1;
    check("pre_rst_ramREN", ramREN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_ramREN", ramREN, 1'b0);
    check("async_rst_dmemload", dmemload, 32'h0);
    dmemREN  = 1'b0;
    exp_load = 32'h0000_0000;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      noise();
      @(posedge CLK);
      #1;
      check("post_rst_dhit", dhit, 1'b0);
      check("post_rst_ramREN", ramREN, 1'b0);
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(1, 3);
      a = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = $urandom_range(0, TO_EN ? 6 : 5);
      t = TO_EN && (w + 1 > TO_P);
      f = 0;
      if (a[1:0] == 2'b00 && !t && $urandom_range(0, 5) == 0) f = $urandom_range(1, w + 1);
      txn(r[0], r[1], a, $urandom, w, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
